// File: rtl/icache_ctrl_pkg.sv
// rtl/icache_ctrl_pkg.sv - shared constants, state encoding and field helpers for the instruction cache
package icache_ctrl_pkg;

  localparam int ADDR_W             = 16;
  localparam int WORD_W             = 16;
  localparam int DEF_NUM_SETS       = 32;
  localparam int DEF_WORDS_PER_LINE = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  // Tag takes whatever is left above the index, offset and byte-select bit.
  function automatic int tag_width(input int sets, input int words);
    return ADDR_W - 1 - $clog2(words) - $clog2(sets);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - cache word storage, combinational read port and one synchronous write port
module icache_data_array
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_SETS       = DEF_NUM_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int IDX_W         = $clog2(NUM_SETS),
  localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [OFF_W-1:0]  rd_offset,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [OFF_W-1:0]  wr_offset,
  input  logic [WORD_W-1:0] wr_data
);

  logic [WORD_W-1:0] mem [NUM_SETS*WORDS_PER_LINE];

  assign rd_data = mem[{rd_index, rd_offset}];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_index, wr_offset}] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller with blocking line fill
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_SETS       = DEF_NUM_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_en,
  output logic [WORD_W-1:0] instruction,
  output logic              stall,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              mem_valid
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = tag_width(NUM_SETS, WORDS_PER_LINE);
  localparam int IDX_LO = OFF_W + 1;
  localparam int TAG_LO = IDX_LO + IDX_W;

  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic              unused_byte_sel;

  state_t            state, state_n;
  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]  tag_mem [NUM_SETS];
  logic [ADDR_W-1:0] base_addr;
  logic [OFF_W-1:0]  fill_cnt;
  logic [IDX_W-1:0]  fill_index;
  logic [TAG_W-1:0]  fill_tag;

  logic              hit;
  logic              fill_start;
  logic              word_accept;
  logic              fill_done;
  logic [WORD_W-1:0] rd_word;

  assign offset          = fetch_addr[IDX_LO-1:1];
  assign index           = fetch_addr[TAG_LO-1:IDX_LO];
  assign tag             = fetch_addr[ADDR_W-1:TAG_LO];
  assign unused_byte_sel = fetch_addr[0];

  // The fill always targets the latched line, never the live fetch address.
  assign fill_index = base_addr[TAG_LO-1:IDX_LO];
  assign fill_tag   = base_addr[ADDR_W-1:TAG_LO];

  assign hit      = valid[index] && (tag_mem[index] == tag);
  assign mem_rd   = (state == ST_FILL);
  assign mem_addr = base_addr;

  icache_data_array #(
    .NUM_SETS       (NUM_SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data_array (
    .clk       (clk),
    .rd_index  (index),
    .rd_offset (offset),
    .rd_data   (rd_word),
    .wr_en     (word_accept),
    .wr_index  (fill_index),
    .wr_offset (fill_cnt),
    .wr_data   (mem_data)
  );

  always_comb begin
    state_n     = state;
    instruction = '0;
    stall       = 1'b0;
    fill_start  = 1'b0;
    word_accept = 1'b0;
    fill_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fetch_en) begin
          if (hit) begin
            instruction = rd_word;
          end else begin
            stall      = 1'b1;
            fill_start = 1'b1;
            state_n    = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        stall = 1'b1;
        if (mem_valid) begin
          word_accept = 1'b1;
          if (fill_cnt == OFF_W'(WORDS_PER_LINE - 1)) begin
            fill_done = 1'b1;
            state_n   = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      valid     <= '0;
      fill_cnt  <= '0;
      base_addr <= '0;
    end else begin
      state <= state_n;
      // Dropping the victim at miss time keeps a half-written line from ever hitting.
      if (fill_start) begin
        base_addr    <= {fetch_addr[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}};
        valid[index] <= 1'b0;
      end
      if (word_accept) begin
        fill_cnt <= fill_done ? '0 : fill_cnt + OFF_W'(1);
      end
      if (fill_done) begin
        valid[fill_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_index] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - self-checking bench: directed vectors, multi-cycle fill sequences, random traffic vs line model
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_addr;
  logic        fetch_en;
  logic [15:0] instruction;
  logic        stall;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: one line per set, identified by its full line address.
  bit          mdl_valid [32];
  logic [15:0] mdl_line  [32];
  logic [15:0] mdl_data  [32][8];

  typedef struct {
    logic [15:0] addr;
    logic        en;
    logic        exp_stall;
    logic [15:0] exp_instr;
  } vec_t;
  vec_t vecs [10];

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_addr  (fetch_addr),
    .fetch_en    (fetch_en),
    .instruction (instruction),
    .stall       (stall),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] line_of(input logic [15:0] a);
    return {a[15:4], 4'h0};
  endfunction

  task automatic model_fill(input logic [15:0] a, input logic [15:0] first);
    int ix;
    ix = int'(a[8:4]);
    mdl_valid[ix] = 1'b1;
    mdl_line[ix]  = line_of(a);
    for (int w = 0; w < 8; w++) mdl_data[ix][w] = first + 16'(w);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl_valid[i] = 1'b0;
  endtask

  // Called one cycle into FILL; returns one cycle after the last word is accepted.
  task automatic serve_fill(input logic [15:0] base, input logic [15:0] first, input int gap,
                            input bit redir, input logic [15:0] raddr, input int nwords);
    for (int w = 0; w < nwords; w++) begin
      for (int g = 0; g < gap; g++) begin
        mem_valid = 1'b0;
        mem_data  = 16'hDEAD;
        #1;
        chk1("fill_gap_stall", stall, 1'b1);
        chk1("fill_gap_mem_rd", mem_rd, 1'b1);
        tick();
      end
      if (redir && w == 3) fetch_addr = raddr;
      mem_valid = 1'b1;
      mem_data  = first + 16'(w);
      #1;
      chk1("fill_mem_rd", mem_rd, 1'b1);
      chk16("fill_mem_addr", mem_addr, base);
      chk1("fill_stall", stall, 1'b1);
      chk16("fill_instr", instruction, 16'h0000);
      tick();
    end
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] a, first, raddr;
    int          ix, gap;
    bit          redir;

    vecs[0] = '{16'h0002, 1'b1, 1'b0, 16'h1001};
    vecs[1] = '{16'h0004, 1'b1, 1'b0, 16'h1002};
    vecs[2] = '{16'h0006, 1'b1, 1'b0, 16'h1003};
    vecs[3] = '{16'h0008, 1'b1, 1'b0, 16'h1004};
    vecs[4] = '{16'h000A, 1'b1, 1'b0, 16'h1005};
    vecs[5] = '{16'h000C, 1'b1, 1'b0, 16'h1006};
    vecs[6] = '{16'h000E, 1'b1, 1'b0, 16'h1007};
    vecs[7] = '{16'h0001, 1'b1, 1'b0, 16'h1000};
    vecs[8] = '{16'h1230, 1'b0, 1'b0, 16'h0000};
    vecs[9] = '{16'h0004, 1'b0, 1'b0, 16'h0000};

    rst = 1'b1; fetch_en = 1'b0; fetch_addr = '0; mem_valid = 1'b0; mem_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk1("reset_stall", stall, 1'b0);
    chk1("reset_mem_rd", mem_rd, 1'b0);
    chk16("reset_mem_addr", mem_addr, 16'h0000);
    chk16("reset_instr", instruction, 16'h0000);

    // Cold miss on line 0, back-to-back fill.
    fetch_en = 1'b1; fetch_addr = 16'h0000;
    #1;
    chk1("cold_stall", stall, 1'b1);
    tick();
    serve_fill(16'h0000, 16'h1000, 0, 1'b0, 16'h0, 8);
    model_fill(16'h0000, 16'h1000);
    chk1("cold_done_stall", stall, 1'b0);
    chk1("cold_done_mem_rd", mem_rd, 1'b0);
    chk16("cold_done_instr", instruction, 16'h1000);

    // Hit sweep and fetch-disabled vectors.
    for (int i = 0; i < 10; i++) begin
      fetch_addr = vecs[i].addr; fetch_en = vecs[i].en;
      #1;
      chk1("vec_stall", stall, vecs[i].exp_stall);
      chk16("vec_instr", instruction, vecs[i].exp_instr);
      chk1("vec_mem_rd", mem_rd, 1'b0);
      tick();
    end
    chk1("en0_no_fill", mem_rd, 1'b0);

    // Conflict at index 0 with tag 1, then line 0 misses again.
    fetch_en = 1'b1; fetch_addr = 16'h0200;
    #1;
    chk1("conflict_stall", stall, 1'b1);
    tick();
    serve_fill(16'h0200, 16'h2000, 0, 1'b0, 16'h0, 8);
    model_fill(16'h0200, 16'h2000);
    chk16("conflict_hit", instruction, 16'h2000);
    fetch_addr = 16'h0000;
    #1;
    chk1("evicted_miss", stall, 1'b1);
    tick();

    // Gapped refill with a redirect to 0x0410 partway through.
    serve_fill(16'h0000, 16'h3000, 2, 1'b1, 16'h0410, 8);
    model_fill(16'h0000, 16'h3000);
    chk1("redir_done_mem_rd", mem_rd, 1'b0);
    chk1("redir_miss", stall, 1'b1);
    tick();
    serve_fill(16'h0410, 16'h4100, 1, 1'b0, 16'h0, 8);
    model_fill(16'h0410, 16'h4100);
    chk16("redir_line_hit", instruction, 16'h4100);
    for (int w = 0; w < 8; w++) begin
      fetch_addr = 16'(w * 2);
      #1;
      chk1("gapped_stall", stall, 1'b0);
      chk16("gapped_word", instruction, 16'h3000 + 16'(w));
    end

    // Reset after four words of a fill.
    fetch_addr = 16'h0820;
    #1;
    chk1("rstfill_miss", stall, 1'b1);
    tick();
    serve_fill(16'h0820, 16'h5000, 0, 1'b0, 16'h0, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    chk1("rstfill_mem_rd", mem_rd, 1'b0);
    chk16("rstfill_mem_addr", mem_addr, 16'h0000);
    chk1("rstfill_refetch_miss", stall, 1'b1);
    fetch_addr = 16'h0000;
    #1;
    chk1("rst_cleared_valid", stall, 1'b1);

    // Random traffic over a small set of indices and tags so conflicts recur.
    for (int it = 0; it < 80; it++) begin
      a = 16'($urandom_range(0, 2) * 512 + $urandom_range(0, 3) * 16 +
              $urandom_range(0, 7) * 2 + $urandom_range(0, 1));
      fetch_en   = ($urandom_range(0, 4) != 0);
      fetch_addr = a;
      mem_valid  = ($urandom_range(0, 3) == 0);
      mem_data   = 16'($urandom);
      ix = int'(a[8:4]);
      #1;
      if (!fetch_en) begin
        chk1("rnd_off_stall", stall, 1'b0);
        chk16("rnd_off_instr", instruction, 16'h0000);
        tick();
      end else if (mdl_valid[ix] && mdl_line[ix] == line_of(a)) begin
        chk1("rnd_hit_stall", stall, 1'b0);
        chk16("rnd_hit_instr", instruction, mdl_data[ix][int'(a[3:1])]);
        tick();
      end else begin
        chk1("rnd_miss_stall", stall, 1'b1);
        tick();
        first = 16'($urandom);
        gap   = $urandom_range(0, 2);
        redir = ($urandom_range(0, 1) == 1);
        raddr = 16'($urandom_range(0, 2) * 512 + $urandom_range(0, 3) * 16);
        serve_fill(line_of(a), first, gap, redir, raddr, 8);
        model_fill(a, first);
        chk1("rnd_fill_done_mem_rd", mem_rd, 1'b0);
      end
      chk1("rnd_idle_mem_rd", mem_rd, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
